chacha20_block_seq: RTL and testbench
=====================================

Name: chacha20_block_seq

Overview:
Sequential ChaCha20 block-function engine built around a single quarter-round datapath, reused over successive cycles. A 16-word state is streamed in DIN_W bits per beat through a valid/ready port. The block runs ROUNDS rounds at one quarter-round per cycle, with optional feed-forward of the input state, and streams the 512-bit result out DIN_W bits per beat. It serves as the tile-level successor to the combinational quarter-round exerciser, scaled to a full block.

Parameters:
DIN_W, 4, in/out stream width in bits; must divide 32 (1,2,4,8,16,32)
ROUNDS, 20, number of rounds (column/diagonal alternating); legal range 1..255
FEED_FORWARD, 1, 1 = add original input state to result before output; 0 = raw round output, and the copy register is omitted

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
in_valid  input  1  in_data beat valid
in_ready  output  1  block accepts input beat (high only in LOAD)
in_data  input  DIN_W  input beat
out_valid  output  1  out_data beat valid (high only in OUT)
out_ready  input  1  consumer accepts output beat
out_data  output  DIN_W  output beat
busy  output  1  high in CALC or FF

Behaviour:
- State registers: s[0..15] (32b each); if FEED_FORWARD, also x[0..15] (copy of input); beat counter cnt (log2(512/DIN_W) bits); round counter rnd (8b); qr index q (2b); FSM {LOAD, CALC, FF, OUT}.
- Reset (any state, including mid-operation): FSM=LOAD, cnt=0, rnd=0, q=0. Next-cycle outputs: in_ready=1, out_valid=0, busy=0, out_data=0. s/x contents are don't-care. Reset has priority over every handshake in the same cycle.
- Beat ordering, both directions: word 0 first, least-significant DIN_W bits of each word first. Beat k maps to word k/(32/DIN_W), bits [(k mod 32/DIN_W)*DIN_W +: DIN_W].
- LOAD: on in_valid&&in_ready, write the beat into s (and x), then cnt++. On the beat where cnt = 512/DIN_W-1: cnt←0, FSM←CALC. With in_valid low, nothing changes.
- CALC: each cycle, apply one quarter-round to four words of s, in place.
  - rnd even (column round): q=0..3 → (q, q+4, q+8, q+12).
  - rnd odd (diagonal round): (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - Quarter-round: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7.
  - All additions are mod 2^32; rotates are left.
  - q++ each cycle; q wraps 3→0 with rnd++.
  - After the cycle with rnd=ROUNDS-1, q=3: FSM←FF if FEED_FORWARD else OUT; rnd←0.
  - CALC lasts exactly 4*ROUNDS cycles.
- FF (one cycle): s[i] ← s[i]+x[i] mod 2^32 for all i; FSM←OUT.
- OUT: out_data = combinational select of beat cnt from s; out_valid=1.
  - On out_valid&&out_ready: cnt++.
  - On the last beat: cnt←0, FSM←LOAD, and in_ready=1 on the next cycle.
  - out_data holds steady while out_ready is low.
- Latency: the last input beat is accepted at edge T; the first out_valid appears after edge T+4*ROUNDS (+1 if FEED_FORWARD). Throughput with both sides always ready: 2*512/DIN_W + 4*ROUNDS + FEED_FORWARD cycles per block.
- in_valid is ignored outside LOAD; out_ready is ignored outside OUT. There is no input/output overlap: a new block cannot load while OUT is draining.
- busy = (FSM==CALC)||(FSM==FF).

Test Plan:
- Reset/idle: assert reset for 2 cycles mid-CALC → next cycle in_ready=1, out_valid=0, busy=0, out_data=0; a subsequent full load restarts cleanly with cnt from 0.
- Single column round (ROUNDS=1, FEED_FORWARD=0, DIN_W=4): s0=11111111, s4=01020304, s8=9b8d6f43, s12=01234567, all other words 0 → output words 0/4/8/12 = ea2a92f4/cb1cf8ce/4581472e/5881c4bb, all others 0. Verify by unpacking 128 nibbles LS-first.
- RFC 7539 §2.3.2 block (defaults): constants, key 00..1f, counter 1, nonce 00000009 0000004a 00000000 → out words 0..3 = e4e7f110 15593bd1 1fdd0f50 c47120a3. out_valid appears exactly 81 cycles after the last input beat.
- Same vector with FEED_FORWARD=0 → out words 0..3 = 837778ab e238d763 a67ae21e 5950bb2f. Latency is 80 cycles.
- Backpressure: random in_valid/out_ready gaps (~50%) with DIN_W=8 → identical result to the gap-free run. out_data stays stable while out_ready=0. in_ready is never high outside LOAD.
- Back-to-back blocks: two blocks with counter 1 then 2 → second block output matches the reference model. in_ready rises the cycle after the final output beat.

Source files
------------

// File: rtl/chacha20_block_seq.sv
// ChaCha20 block engine: one quarter-round per cycle over a 16-word state,
// with streamed load/unload and optional feed-forward of the input state.
module chacha20_block_seq #(
  parameter int unsigned DIN_W        = 4,
  parameter int unsigned ROUNDS       = 20,
  parameter int unsigned FEED_FORWARD = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DIN_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIN_W-1:0] out_data,
  output logic             busy
);

  localparam int unsigned BEATS = 512 / DIN_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned BPW   = 32 / DIN_W;

  typedef enum logic [1:0] {ST_LOAD, ST_CALC, ST_FF, ST_OUT} state_e;

  state_e           fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       rnd_q, rnd_d;
  logic [1:0]       q_q, q_d;
  logic [31:0]      s_q [16];
  logic [31:0]      s_d [16];
  logic [31:0]      ff_sum [16];

  logic [3:0]  w_idx;
  logic [4:0]  b_off;
  logic        in_fire, out_fire, last_beat;
  logic [3:0]  ia, ib, ic, id;
  logic [31:0] qa, qb, qc, qd;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  always_comb begin
    in_fire   = in_valid && (fsm_q == ST_LOAD);
    out_fire  = out_ready && (fsm_q == ST_OUT);
    w_idx     = 4'(32'(cnt_q) / BPW);
    b_off     = 5'((32'(cnt_q) % BPW) * DIN_W);
    last_beat = (cnt_q == CNT_W'(BEATS - 1));
  end

  // Diagonal rounds rotate the b/c/d rows by 1/2/3 words relative to column q.
  always_comb begin
    ia = {2'b00, q_q};
    if (rnd_q[0]) begin
      ib = {2'b01, q_q + 2'd1};
      ic = {2'b10, q_q + 2'd2};
      id = {2'b11, q_q + 2'd3};
    end else begin
      ib = {2'b01, q_q};
      ic = {2'b10, q_q};
      id = {2'b11, q_q};
    end
  end

  always_comb begin
    qa = s_q[ia];
    qb = s_q[ib];
    qc = s_q[ic];
    qd = s_q[id];
    qa = qa + qb; qd = rotl(qd ^ qa, 16);
    qc = qc + qd; qb = rotl(qb ^ qc, 12);
    qa = qa + qb; qd = rotl(qd ^ qa, 8);
    qc = qc + qd; qb = rotl(qb ^ qc, 7);
  end

  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    rnd_d = rnd_q;
    q_d   = q_q;
    s_d   = s_q;
    case (fsm_q)
      ST_LOAD: begin
        if (in_fire) begin
          s_d[w_idx][b_off +: DIN_W] = in_data;
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) fsm_d = ST_CALC;
        end
      end
      ST_CALC: begin
        s_d[ia] = qa;
        s_d[ib] = qb;
        s_d[ic] = qc;
        s_d[id] = qd;
        q_d = q_q + 2'd1;
        if (q_q == 2'd3) begin
          if (rnd_q == 8'(ROUNDS - 1)) begin
            rnd_d = '0;
            fsm_d = (FEED_FORWARD != 0) ? ST_FF : ST_OUT;
          end else begin
            rnd_d = rnd_q + 8'd1;
          end
        end
      end
      ST_FF: begin
        s_d   = ff_sum;
        fsm_d = ST_OUT;
      end
      ST_OUT: begin
        if (out_fire) begin
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) fsm_d = ST_LOAD;
        end
      end
      default: fsm_d = ST_LOAD;
    endcase
  end

  generate
    if (FEED_FORWARD != 0) begin : g_ff
      logic [31:0] x_q [16];
      logic [31:0] x_d [16];
      always_comb begin
        x_d = x_q;
        if (in_fire) x_d[w_idx][b_off +: DIN_W] = in_data;
        for (int unsigned i = 0; i < 16; i++) ff_sum[i] = s_q[i] + x_q[i];
      end
      always_ff @(posedge clk) x_q <= x_d;
    end else begin : g_no_ff
      always_comb ff_sum = s_q;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= ST_LOAD;
      cnt_q <= '0;
      rnd_q <= '0;
      q_q   <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      rnd_q <= rnd_d;
      q_q   <= q_d;
    end
  end

  always_ff @(posedge clk) s_q <= s_d;

  assign in_ready  = (fsm_q == ST_LOAD);
  assign out_valid = (fsm_q == ST_OUT);
  assign busy      = (fsm_q == ST_CALC) || (fsm_q == ST_FF);
  assign out_data  = (fsm_q == ST_OUT) ? s_q[w_idx][b_off +: DIN_W] : '0;

endmodule

// File: tb/tb_chacha20_block_seq.sv
// Directed bench for chacha20_block_seq: four parameterisations share one
// stimulus port, selected by sel, checked against RFC 7539 vectors.
module tb_chacha20_block_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, out_ready;
  logic [7:0] in_data;
  int         sel;

  logic [3:0] iv, orr, ir, ov, bz;
  logic [3:0] od0, od1, od2;
  logic [7:0] od3;
  logic       cur_ir, cur_ov, cur_bz;
  logic [7:0] cur_od;

  logic [31:0] in_w [16];
  logic [31:0] res_w [16];
  logic [31:0] exp_w [16];
  logic [31:0] ref_w [16];
  int          compared, mismatched, ir_bad;
  logic        ir_at_last;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      iv[i]  = in_valid && (sel == i);
      orr[i] = out_ready && (sel == i);
    end
    cur_ir = ir[sel[1:0]];
    cur_ov = ov[sel[1:0]];
    cur_bz = bz[sel[1:0]];
    case (sel)
      0:       cur_od = {4'b0, od0};
      1:       cur_od = {4'b0, od1};
      2:       cur_od = {4'b0, od2};
      default: cur_od = od3;
    endcase
  end

  chacha20_block_seq #(.DIN_W(4), .ROUNDS(1), .FEED_FORWARD(0)) u_r1 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in_data[3:0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_data(od0), .busy(bz[0]));
  chacha20_block_seq #(.DIN_W(4), .ROUNDS(20), .FEED_FORWARD(1)) u_def (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in_data[3:0]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_data(od1), .busy(bz[1]));
  chacha20_block_seq #(.DIN_W(4), .ROUNDS(20), .FEED_FORWARD(0)) u_nff (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in_data[3:0]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_data(od2), .busy(bz[2]));
  chacha20_block_seq #(.DIN_W(8), .ROUNDS(20), .FEED_FORWARD(1)) u_w8 (
    .clk(clk), .reset(reset), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(in_data),
    .out_valid(ov[3]), .out_ready(orr[3]), .out_data(od3), .busy(bz[3]));

  always @(negedge clk)
    if (!reset && cur_ir && (cur_ov || cur_bz)) ir_bad++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] qrf(input logic [31:0] a0, b0, c0, d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  task automatic model(input int unsigned rounds, input bit ff);
    logic [31:0] x [16];
    int unsigned ix [4];
    int unsigned dg [4][4];
    dg = '{'{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
    for (int i = 0; i < 16; i++) x[i] = in_w[i];
    for (int unsigned r = 0; r < rounds; r++)
      for (int unsigned j = 0; j < 4; j++) begin
        if (r % 2 == 0) ix = '{j, j + 4, j + 8, j + 12};
        else for (int m = 0; m < 4; m++) ix[m] = dg[j][m];
        {x[ix[0]], x[ix[1]], x[ix[2]], x[ix[3]]} = qrf(x[ix[0]], x[ix[1]], x[ix[2]], x[ix[3]]);
      end
    for (int i = 0; i < 16; i++) exp_w[i] = ff ? x[i] + in_w[i] : x[i];
  endtask

  task automatic set_rfc(input logic [31:0] ctr);
    in_w[0] = 32'h61707865; in_w[1] = 32'h3320646e;
    in_w[2] = 32'h79622d32; in_w[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++)
      in_w[4+i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    in_w[12] = ctr;
    in_w[13] = 32'h09000000;
    in_w[14] = 32'h4a000000;
    in_w[15] = 32'h00000000;
  endtask

  task automatic load_block(input bit gaps);
    int unsigned dw, bpw, nb, n;
    logic [31:0] w;
    dw = (sel == 3) ? 8 : 4;
    bpw = 32 / dw;
    nb = 512 / dw;
    for (int unsigned k = 0; k < nb; k++) begin
      if (gaps)
        while ($urandom_range(1, 0) == 0) begin
          in_valid = 1'b0;
          in_data = 8'($urandom);
          tick();
        end
      w = in_w[k / bpw] >> ((k % bpw) * dw);
      in_data = (dw == 8) ? w[7:0] : {4'b0, w[3:0]};
      in_valid = 1'b1;
      n = 0;
      while (!cur_ir && n < 50) begin tick(); n++; end
      if (!cur_ir) begin
        compared++; mismatched++;
        $display("FAIL load_wait: in_ready=%b required 1 at beat %0d", cur_ir, k);
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned exp_lat, input string name);
    int unsigned n;
    n = 0;
    while (!cur_ov && n < 400) begin tick(); n++; end
    compared++;
    if (n !== exp_lat) begin
      mismatched++;
      $display("FAIL %s_latency: got %0d cycles required %0d", name, n, exp_lat);
    end
  endtask

  task automatic read_block(input bit gaps);
    int unsigned dw, bpw, nb, n, k;
    logic [7:0] hold;
    bit held;
    dw = (sel == 3) ? 8 : 4;
    bpw = 32 / dw;
    nb = 512 / dw;
    k = 0; n = 0;
    for (int i = 0; i < 16; i++) res_w[i] = '0;
    while (k < nb && n < 4000) begin
      out_ready = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
      held = 1'b0;
      if (cur_ov && out_ready) begin
        res_w[k / bpw] = res_w[k / bpw] | (32'(cur_od) << ((k % bpw) * dw));
        if (k == nb - 1) ir_at_last = cur_ir;
        k++;
      end else if (cur_ov) begin
        hold = cur_od;
        held = 1'b1;
      end
      tick();
      n++;
      if (held) begin
        compared++;
        if (cur_od !== hold || cur_ov !== 1'b1) begin
          mismatched++;
          $display("FAIL out_hold: data=%h valid=%b required data=%h valid=1", cur_od, cur_ov, hold);
        end
      end
    end
    out_ready = 1'b0;
    if (k < nb) begin
      compared++; mismatched++;
      $display("FAIL read_timeout: got %0d beats required %0d", k, nb);
    end
  endtask

  task automatic test_reset();
    sel = 1;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    compared += 4;
    if (cur_ir !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b required 1", cur_ir); end
    if (cur_ov !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b required 0", cur_ov); end
    if (cur_bz !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b required 0", cur_bz); end
    if (cur_od !== 8'h00) begin mismatched++; $display("FAIL reset_out_data: got %h required 00", cur_od); end
  endtask

  task automatic test_column_round();
    sel = 0;
    for (int i = 0; i < 16; i++) begin in_w[i] = '0; exp_w[i] = '0; end
    in_w[0] = 32'h11111111; in_w[4] = 32'h01020304;
    in_w[8] = 32'h9b8d6f43; in_w[12] = 32'h01234567;
    exp_w[0] = 32'hea2a92f4; exp_w[4] = 32'hcb1cf8ce;
    exp_w[8] = 32'h4581472e; exp_w[12] = 32'h5881c4bb;
    load_block(1'b0);
    wait_valid(4, "column");
    read_block(1'b0);
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (res_w[i] !== exp_w[i]) begin
        mismatched++;
        $display("FAIL column_word%0d: got %h required %h", i, res_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_rfc_ff();
    sel = 1;
    set_rfc(32'd1);
    model(20, 1'b1);
    exp_w[0] = 32'he4e7f110; exp_w[1] = 32'h15593bd1;
    exp_w[2] = 32'h1fdd0f50; exp_w[3] = 32'hc47120a3;
    load_block(1'b0);
    wait_valid(81, "rfc_ff");
    read_block(1'b0);
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (res_w[i] !== exp_w[i]) begin
        mismatched++;
        $display("FAIL rfc_ff_word%0d: got %h required %h", i, res_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_rfc_noff();
    sel = 2;
    set_rfc(32'd1);
    model(20, 1'b0);
    exp_w[0] = 32'h837778ab; exp_w[1] = 32'he238d763;
    exp_w[2] = 32'ha67ae21e; exp_w[3] = 32'h5950bb2f;
    load_block(1'b0);
    wait_valid(80, "rfc_noff");
    read_block(1'b0);
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (res_w[i] !== exp_w[i]) begin
        mismatched++;
        $display("FAIL rfc_noff_word%0d: got %h required %h", i, res_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [31:0] rfc [4];
    rfc = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3};
    sel = 1;
    set_rfc(32'd1);
    load_block(1'b0);
    repeat (10) tick();
    compared++;
    if (cur_bz !== 1'b1) begin mismatched++; $display("FAIL midcalc_busy: got %b required 1", cur_bz); end
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    compared += 4;
    if (cur_ir !== 1'b1) begin mismatched++; $display("FAIL midreset_in_ready: got %b required 1", cur_ir); end
    if (cur_ov !== 1'b0) begin mismatched++; $display("FAIL midreset_out_valid: got %b required 0", cur_ov); end
    if (cur_bz !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %b required 0", cur_bz); end
    if (cur_od !== 8'h00) begin mismatched++; $display("FAIL midreset_out_data: got %h required 00", cur_od); end
    load_block(1'b0);
    wait_valid(81, "restart");
    read_block(1'b0);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (res_w[i] !== rfc[i]) begin
        mismatched++;
        $display("FAIL restart_word%0d: got %h required %h", i, res_w[i], rfc[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    sel = 3;
    set_rfc(32'd1);
    model(20, 1'b1);
    load_block(1'b0);
    wait_valid(81, "w8_nogap");
    read_block(1'b0);
    for (int i = 0; i < 16; i++) ref_w[i] = res_w[i];
    ir_bad = 0;
    load_block(1'b1);
    wait_valid(81, "w8_gap");
    read_block(1'b1);
    for (int i = 0; i < 16; i++) begin
      compared += 2;
      if (res_w[i] !== ref_w[i]) begin
        mismatched++;
        $display("FAIL gap_vs_nogap_word%0d: got %h required %h", i, res_w[i], ref_w[i]);
      end
      if (res_w[i] !== exp_w[i]) begin
        mismatched++;
        $display("FAIL gap_model_word%0d: got %h required %h", i, res_w[i], exp_w[i]);
      end
    end
    compared++;
    if (ir_bad !== 0) begin
      mismatched++;
      $display("FAIL in_ready_outside_load: got %0d cycles required 0", ir_bad);
    end
  endtask

  task automatic test_back_to_back();
    sel = 1;
    for (int b = 1; b <= 2; b++) begin
      set_rfc(32'(b));
      model(20, 1'b1);
      ir_at_last = 1'bx;
      load_block(1'b0);
      wait_valid(81, "b2b");
      read_block(1'b0);
      compared += 2;
      if (ir_at_last !== 1'b0) begin
        mismatched++;
        $display("FAIL b2b_ready_during_last: got %b required 0", ir_at_last);
      end
      if (cur_ir !== 1'b1) begin
        mismatched++;
        $display("FAIL b2b_ready_after_last: got %b required 1", cur_ir);
      end
      for (int i = 0; i < 16; i++) begin
        compared++;
        if (res_w[i] !== exp_w[i]) begin
          mismatched++;
          $display("FAIL b2b_blk%0d_word%0d: got %h required %h", b, i, res_w[i], exp_w[i]);
        end
      end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    ir_bad = 0;
    sel = 1;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    test_reset();
    test_column_round();
    test_rfc_ff();
    test_rfc_noff();
    test_reset_mid_calc();
    test_backpressure();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
